// File: rtl/tt_xbar_slave_arb_if.sv
// tt_xbar_slave_arb_if: master-side and slave-side buses of one crossbar slave port
interface tt_xbar_slave_arb_if #(
   parameter int NUM_MASTER = 2
);
   localparam int GW = NUM_MASTER > 1 ? $clog2(NUM_MASTER) : 1;
   logic [NUM_MASTER-1:0]    master_req;
   logic [32*NUM_MASTER-1:0] master_addr;
   logic [NUM_MASTER-1:0]    master_cmd;
   logic [32*NUM_MASTER-1:0] master_wdata;
   logic [NUM_MASTER-1:0]    master_ack;
   logic [NUM_MASTER-1:0]    master_err;
   logic [31:0]              master_rdata;
   logic                     slave_req;
   logic [31:0]              slave_addr;
   logic                     slave_cmd;
   logic [31:0]              slave_wdata;
   logic                     slave_ack;
   logic [31:0]              slave_rdata;
   logic                     busy;
   logic [GW-1:0]            grant_id;
   modport master (
      output master_req, master_addr, master_cmd, master_wdata, slave_ack, slave_rdata,
      input  master_ack, master_err, master_rdata, slave_req, slave_addr, slave_cmd, slave_wdata, busy, grant_id
   );
   modport slave (
      input  master_req, master_addr, master_cmd, master_wdata, slave_ack, slave_rdata,
      output master_ack, master_err, master_rdata, slave_req, slave_addr, slave_cmd, slave_wdata, busy, grant_id
   );
endinterface

// File: rtl/tt_xbar_slave_arb.sv
// tt_xbar_slave_arb: per-slave round-robin arbiter and sequencer with timeout abort
module tt_xbar_slave_arb #(
   parameter int          NUM_MASTER     = 2,
   parameter logic [31:0] SLAVE_BASE     = 32'h0000_0000,
   parameter logic [31:0] SLAVE_MASK     = 32'hF000_0000,
   parameter int          TIMEOUT_CYCLES = 256
) (
   input logic                clk,
   input logic                rst,
   tt_xbar_slave_arb_if.slave bus
);
   localparam int GW = NUM_MASTER > 1 ? $clog2(NUM_MASTER) : 1;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t                state;
   logic [NUM_MASTER-1:0] elig;
   logic [NUM_MASTER-1:0] grant_oh;
   logic [GW-1:0]         rr_ptr;
   logic [GW-1:0]         pick;
   logic [GW-1:0]         idx;
   logic [GW-1:0]         next_ptr;
   logic [31:0]           cnt;
   logic                  to_hit;
   // address decode, round-robin pick starting at rr_ptr, and timeout detect
   always_comb begin
      elig = '0;
      grant_oh = '0;
      pick = '0;
      idx = '0;
      for (int i = 0; i < NUM_MASTER; i++) begin
         elig[i] = bus.master_req[i] && ((bus.master_addr[32*i +: 32] & SLAVE_MASK) == SLAVE_BASE);
         grant_oh[i] = (GW'(i) == bus.grant_id);
      end
      for (int k = NUM_MASTER - 1; k >= 0; k--) begin
         idx = GW'((int'(rr_ptr) + k) % NUM_MASTER);
         pick = elig[idx] ? idx : pick;
      end
      next_ptr = GW'((int'(bus.grant_id) + 1) % NUM_MASTER);
      to_hit = (TIMEOUT_CYCLES != 0) && (cnt == 32'(TIMEOUT_CYCLES - 1));
   end
   // arbitration FSM driving every bus output from registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rr_ptr <= '0;
         cnt <= '0;
         bus.slave_req <= 1'b0;
         bus.slave_addr <= '0;
         bus.slave_cmd <= 1'b0;
         bus.slave_wdata <= '0;
         bus.master_ack <= '0;
         bus.master_err <= '0;
         bus.master_rdata <= '0;
         bus.busy <= 1'b0;
         bus.grant_id <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|elig) begin
                  bus.grant_id <= pick;
                  bus.slave_addr <= bus.master_addr[32*pick +: 32];
                  bus.slave_cmd <= bus.master_cmd[pick];
                  bus.slave_wdata <= bus.master_wdata[32*pick +: 32];
                  bus.slave_req <= 1'b1;
                  bus.busy <= 1'b1;
                  state <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt + 32'd1;
               if (bus.slave_ack || to_hit) begin
                  bus.slave_req <= 1'b0;
                  bus.master_ack <= grant_oh;
                  bus.master_err <= bus.slave_ack ? '0 : grant_oh;
                  bus.master_rdata <= bus.slave_ack ? bus.slave_rdata : 32'hDEAD_BEEF;
                  state <= RESP;
               end
            end
            default: begin
               bus.master_ack <= '0;
               bus.master_err <= '0;
               bus.busy <= 1'b0;
               rr_ptr <= next_ptr;
               cnt <= '0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_tt_xbar_slave_arb.sv
// tb_tt_xbar_slave_arb: directed self-checking bench for tt_xbar_slave_arb
module tb_tt_xbar_slave_arb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail = 0;
   tt_xbar_slave_arb_if #(.NUM_MASTER(2)) bus ();
   tt_xbar_slave_arb #(
      .NUM_MASTER    (2),
      .SLAVE_BASE    (32'h0000_0000),
      .SLAVE_MASK    (32'hF000_0000),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   initial begin
      bus.master_req = '0;
      bus.master_addr = '0;
      bus.master_cmd = '0;
      bus.master_wdata = '0;
      bus.slave_ack = 1'b0;
      bus.slave_rdata = '0;
      step();
      step();
      chk("rst_slave_req", 32'(bus.slave_req), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_grant", 32'(bus.grant_id), 0);
      chk("rst_ack", 32'(bus.master_ack), 0);
      chk("rst_err", 32'(bus.master_err), 0);
      chk("rst_rdata", bus.master_rdata, 0);
      chk("rst_saddr", bus.slave_addr, 0);
      rst = 1'b0;
      // single read from M0, slave acks three cycles after slave_req
      bus.master_req = 2'b01;
      bus.master_addr[31:0] = 32'h0000_0010;
      bus.master_cmd = 2'b00;
      step();
      chk("rd_slave_req_c1", 32'(bus.slave_req), 1);
      chk("rd_busy_c1", 32'(bus.busy), 1);
      chk("rd_saddr", bus.slave_addr, 32'h0000_0010);
      chk("rd_scmd", 32'(bus.slave_cmd), 0);
      chk("rd_grant", 32'(bus.grant_id), 0);
      for (int c = 2; c <= 4; c++) begin
         step();
         chk("rd_slave_req_hold", 32'(bus.slave_req), 1);
         chk("rd_no_ack_yet", 32'(bus.master_ack), 0);
      end
      bus.slave_ack = 1'b1;
      bus.slave_rdata = 32'h1234_5678;
      step();
      bus.slave_ack = 1'b0;
      bus.slave_rdata = '0;
      bus.master_req = 2'b00;
      chk("rd_ack", 32'(bus.master_ack), 32'h1);
      chk("rd_err", 32'(bus.master_err), 0);
      chk("rd_rdata", bus.master_rdata, 32'h1234_5678);
      chk("rd_slave_req_off", 32'(bus.slave_req), 0);
      chk("rd_busy_resp", 32'(bus.busy), 1);
      step();
      chk("rd_ack_clear", 32'(bus.master_ack), 0);
      chk("rd_busy_off", 32'(bus.busy), 0);
      chk("rd_rdata_hold", bus.master_rdata, 32'h1234_5678);
      // reset to return the round-robin pointer to M0
      rst = 1'b1;
      step();
      rst = 1'b0;
      // round-robin with both masters requesting and an always-acking slave
      bus.master_addr = {32'h0000_0200, 32'h0000_0100};
      bus.master_req = 2'b11;
      bus.slave_ack = 1'b1;
      bus.slave_rdata = 32'hA5A5_0000;
      for (int t = 0; t < 4; t++) begin
         step();
         chk("rr_grant", 32'(bus.grant_id), 32'(t % 2));
         chk("rr_saddr", bus.slave_addr, (t % 2) ? 32'h0000_0200 : 32'h0000_0100);
         step();
         chk("rr_ack", 32'(bus.master_ack), (t % 2) ? 32'h2 : 32'h1);
         chk("rr_rdata", bus.master_rdata, 32'hA5A5_0000);
         step();
         chk("rr_idle", 32'(bus.busy), 0);
         if (t == 3) begin
            bus.master_req = 2'b00;
            bus.slave_ack = 1'b0;
         end
      end
      // M1 targets another slave window and must be ignored
      bus.master_addr[63:32] = 32'h1000_0000;
      bus.master_req = 2'b10;
      for (int c = 0; c < 50; c++) begin
         step();
         chk("miss_quiet", {bus.slave_req, bus.busy, bus.master_ack}, 0);
      end
      bus.master_req = 2'b00;
      // timeout abort of a write from M0 with a silent slave
      bus.master_addr[31:0] = 32'h0000_0020;
      bus.master_cmd = 2'b01;
      bus.master_wdata[31:0] = 32'h0000_CAFE;
      bus.master_req = 2'b01;
      step();
      chk("to_scmd", 32'(bus.slave_cmd), 1);
      chk("to_swdata", bus.slave_wdata, 32'h0000_CAFE);
      chk("to_slave_req_c1", 32'(bus.slave_req), 1);
      for (int c = 2; c <= 8; c++) begin
         step();
         chk("to_slave_req_hold", 32'(bus.slave_req), 1);
         chk("to_no_ack_yet", 32'(bus.master_ack), 0);
      end
      step();
      bus.master_req = 2'b00;
      chk("to_ack", 32'(bus.master_ack), 32'h1);
      chk("to_err", 32'(bus.master_err), 32'h1);
      chk("to_rdata", bus.master_rdata, 32'hDEAD_BEEF);
      chk("to_slave_req_off", 32'(bus.slave_req), 0);
      step();
      chk("to_idle", {bus.busy, bus.master_ack, bus.master_err}, 0);
      // slave ack arriving on the timeout cycle wins over the abort
      bus.master_cmd = 2'b00;
      bus.master_req = 2'b01;
      step();
      chk("col_grant", 32'(bus.grant_id), 0);
      for (int c = 2; c <= 8; c++) step();
      chk("col_slave_req_c8", 32'(bus.slave_req), 1);
      bus.slave_ack = 1'b1;
      bus.slave_rdata = 32'h5555_AAAA;
      step();
      bus.slave_ack = 1'b0;
      bus.master_req = 2'b00;
      chk("col_ack", 32'(bus.master_ack), 32'h1);
      chk("col_err", 32'(bus.master_err), 0);
      chk("col_rdata", bus.master_rdata, 32'h5555_AAAA);
      step();
      chk("col_rdata_hold", bus.master_rdata, 32'h5555_AAAA);
      // stray slave ack in IDLE is ignored
      bus.slave_ack = 1'b1;
      step();
      bus.slave_ack = 1'b0;
      chk("stray_ack", {bus.busy, bus.master_ack}, 0);
      // reset two cycles into BUSY discards the transfer
      bus.master_addr = {32'h0000_0030, 32'h0000_0040};
      bus.master_req = 2'b10;
      step();
      chk("rb_grant", 32'(bus.grant_id), 1);
      step();
      rst = 1'b1;
      step();
      chk("rb_slave_req", 32'(bus.slave_req), 0);
      chk("rb_busy", 32'(bus.busy), 0);
      chk("rb_ack", 32'(bus.master_ack), 0);
      chk("rb_grant_rst", 32'(bus.grant_id), 0);
      chk("rb_rdata", bus.master_rdata, 0);
      rst = 1'b0;
      bus.master_req = 2'b11;
      step();
      chk("rb_first_grant", 32'(bus.grant_id), 0);
      chk("rb_saddr", bus.slave_addr, 32'h0000_0040);
      bus.slave_ack = 1'b1;
      bus.slave_rdata = 32'h0BAD_F00D;
      step();
      bus.slave_ack = 1'b0;
      bus.master_req = 2'b00;
      chk("rb_ack_m0", 32'(bus.master_ack), 32'h1);
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/tt_xbar_slave_arb.md
Name: tt_xbar_slave_arb

Overview:
- Per-slave arbitration and sequencing unit for the tt crossbar. One instance per slave port.
- Decodes master addresses against its slave window and grants one master at a time, round-robin.
- Forwards the granted request to the slave, returns ack/rdata to the granted master, and aborts hung transactions via a timeout.

Parameters:
- NUM_MASTER, 2, number of requesting masters (2..16).
- SLAVE_BASE, 32'h0000_0000, base address of this slave window.
- SLAVE_MASK, 32'hF000_0000, decode mask; master i targets this slave when (master_addr[i] & SLAVE_MASK) == SLAVE_BASE.
- TIMEOUT_CYCLES, 256, BUSY cycles without slave_ack before abort; 0 disables the timeout.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous, active-high reset.
- master_req, input, NUM_MASTER, per-master request; held until master_ack.
- master_addr, input, 32*NUM_MASTER, packed; master i at [32*i+31:32*i].
- master_cmd, input, NUM_MASTER, 1 = write, 0 = read.
- master_wdata, input, 32*NUM_MASTER, packed write data.
- master_ack, output, NUM_MASTER, one-cycle completion pulse, one-hot.
- master_err, output, NUM_MASTER, qualifies master_ack; 1 = timeout abort.
- master_rdata, output, 32, read data for the master currently acked.
- slave_req, output, 1, request to slave.
- slave_addr, output, 32, request address.
- slave_cmd, output, 1, request command.
- slave_wdata, output, 32, request write data.
- slave_ack, input, 1, one-cycle slave completion.
- slave_rdata, input, 32, valid with slave_ack.
- busy, output, 1, high in BUSY and RESP.
- grant_id, output, $clog2(NUM_MASTER) (min 1), index of the granted master; holds its last value in IDLE.

Behaviour:
- All outputs are registered.
- Reset values: slave_req=0, slave_addr/slave_cmd/slave_wdata=0, master_ack=0, master_err=0, master_rdata=0, busy=0, grant_id=0, rr_ptr=0, state=IDLE, timeout counter=0.
- Eligible set: E[i] = master_req[i] && address-decode hit.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If E is nonzero, pick the first set bit searching upward from rr_ptr with wrap.
  - Latch grant_id, addr, cmd and wdata of the winner. Set slave_req=1 and busy=1. Go to BUSY.
  - The slave therefore sees the request one cycle after the master's request is sampled.
- BUSY:
  - slave_req and the slave_* buses are held constant. The counter increments each cycle.
  - On slave_ack=1: latch master_rdata=slave_rdata (0 on writes is fine; it is the slave's value), set master_ack[grant_id]=1, master_err=0, slave_req=0. Go to RESP.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 without ack: set slave_req=0, master_ack[grant_id]=1, master_err[grant_id]=1, master_rdata=32'hDEAD_BEEF. Go to RESP.
  - If slave_ack and timeout occur in the same cycle, the ack wins (err=0).
- RESP:
  - Lasts one cycle; the ack/err pulse is visible here.
  - On exit: clear master_ack/master_err, busy=0, rr_ptr=(grant_id+1) mod NUM_MASTER, counter=0. Go to IDLE.
- Latency: minimum request-sampled-to-master_ack is 2 cycles (slave acks in its first BUSY cycle). A new grant is issued no earlier than the cycle after RESP.
- slave_ack outside BUSY is ignored.
- master_rdata holds its value after the ack pulse until the next completion.
- A master that drops req during BUSY does not cancel the transfer; the transfer completes and the ack is still pulsed.
- Non-decoding requests are never granted and never acked by this instance.
- Reset asserted mid-transaction: all outputs take their reset values at the next edge, no ack is delivered, and the in-flight transfer is discarded.
- NUM_MASTER=1 degenerates to a pass-through sequencer; grant_id stays 0.

Test Plan:
- Single read: M0 req, addr 0x0000_0010, cmd 0; slave acks 3 cycles after slave_req with rdata 0x1234_5678 -> slave_req high cycles 1..4, master_ack[0] with rdata 0x1234_5678 one cycle after slave_ack, busy low after.
- Round-robin: M0 and M1 both hold req continuously, slave acks immediately -> grant_id order 0,1,0,1; each transaction takes 3 cycles.
- Decode miss: M1 addr 0x1000_0000 with default base/mask -> no slave_req, no master_ack[1] for 50 cycles.
- Timeout: TIMEOUT_CYCLES=8, slave never acks -> slave_req high exactly 8 cycles, then master_ack[0]=master_err[0]=1 with rdata 0xDEAD_BEEF.
- Ack/timeout collision: slave_ack on the 8th BUSY cycle with TIMEOUT_CYCLES=8 -> master_err=0 and rdata is the slave's value.
- Reset mid-BUSY: assert rst 2 cycles into BUSY -> next cycle slave_req=0, busy=0, no master_ack; after release with both masters requesting, M0 is granted first.
